mult_datapath: RTL

//  Shift-add multiplier datapath driven by the multiplier FSM (load/ad/shift strobes).

---
 rtl/mult_pkg.sv | 11 +
 rtl/mult_acc_shift.sv | 55 +++++
 rtl/mult_datapath.sv | 85 ++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared width defaults and helpers for the shift-add multiplier.
package mult_pkg;
  localparam int MULT_WIDTH = 32;
  localparam int CNT_W      = $clog2(MULT_WIDTH + 1);

  typedef logic [2*MULT_WIDTH-1:0] prod_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/mult_acc_shift.sv
// Accumulator/multiplier shift pair {A,Q}, adder and bit counter; M/K are combinational from regs.
// Latency: one add or shift per cycle; no backpressure, strobes are paced by the multiplier FSM.
module mult_acc_shift
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             load,
  input  logic             ad,
  input  logic             shift,
  input  logic [WIDTH-1:0] q_init,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_lo,
  output logic [WIDTH-1:0] q,
  output logic             M,
  output logic             K
);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_DONE = CW'(WIDTH);

  logic [WIDTH:0]  a;
  logic [WIDTH:0]  a_sum;
  logic [CW-1:0]   cnt;

  assign K    = (cnt == CNT_DONE);
  assign M    = q[0];
  assign a_lo = a[WIDTH-1:0];

  // A carries one extra bit so the add never loses its carry before the shift.
  always_comb begin
    a_sum = a;
    if (ad) a_sum = a + {1'b0, b};
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      a   <= '0;
      q   <= '0;
      cnt <= '0;
    end else if (load) begin
      a   <= '0;
      q   <= q_init;
      cnt <= '0;
    end else if (!K) begin
      if (shift) begin
        {a, q} <= {a_sum, q} >> 1;
        cnt    <= cnt + 1'b1;
      end else begin
        a <= a_sum;
      end
    end
  end
endmodule

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: B, HI/LO result regs, optional sign handling (MULT_SIGNED_EN).
// Latency: product valid 2*WIDTH+2 cycles after load; no backpressure, FSM-paced strobes.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             load,
  input  logic             ad,
  input  logic             shift,
  input  logic             Done,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  input  logic             sgn,
  output logic             M,
  output logic             K,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             valid
);
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   b_init;
  logic [WIDTH-1:0]   q_init;
  logic [WIDTH-1:0]   a_lo;
  logic [WIDTH-1:0]   q;
  logic [2*WIDTH-1:0] prod;

`ifdef MULT_SIGNED_EN
  logic neg;

  // Magnitudes feed the unsigned core; the most-negative value maps to 2^(W-1) unchanged.
  always_comb begin
    q_init = mplier;
    b_init = mcand;
    if (sgn && mplier[WIDTH-1]) q_init = -mplier;
    if (sgn && mcand[WIDTH-1])  b_init = -mcand;
    prod = {a_lo, q};
    if (neg) prod = -{a_lo, q};
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst)       neg <= 1'b0;
    else if (load) neg <= sgn & (mcand[WIDTH-1] ^ mplier[WIDTH-1]);
  end
`else
  logic unused_sgn;

  assign unused_sgn = sgn;
  assign q_init     = mplier;
  assign b_init     = mcand;
  assign prod       = {a_lo, q};
`endif

  mult_acc_shift #(.WIDTH(WIDTH)) u_acc_shift (
    .clock  (clock),
    .rst    (rst),
    .load   (load),
    .ad     (ad),
    .shift  (shift),
    .q_init (q_init),
    .b      (b),
    .a_lo   (a_lo),
    .q      (q),
    .M      (M),
    .K      (K)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      b     <= '0;
      hi    <= '0;
      lo    <= '0;
      valid <= 1'b0;
    end else if (load) begin
      b     <= b_init;
      valid <= 1'b0;
    end else if (Done) begin
      hi    <= prod[2*WIDTH-1:WIDTH];
      lo    <= prod[WIDTH-1:0];
      valid <= 1'b1;
    end
  end
endmodule
